nn_layer_sequencer: RTL and testbench

Initiator side of the weight-pipeline control interface. It drives the 3-bit mode bus (0 idle, 1 load, 2 layer) into the weight pipeline controller and consumes that controller's load_ready, layer_ready and weight_ctrl. While load is active it streams a programmed number of weight rows from an upstream valid/ready source into the MAC array. It then switches to layer mode, sequences the accumulator readout, and reports completion.

---
 rtl/nn_layer_sequencer.sv | 152 +++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_sequencer.sv
// Weight-pipeline initiator: requests load mode, streams weight rows into the MAC array, then reads out the accumulators.
// Optional ready-wait watchdog enabled by defining NN_SEQ_TIMEOUT_EN.
module nn_layer_sequencer #(
    parameter int N_MACS    = 4,
    parameter int W_WIDTH   = 8,
    parameter int MAX_ROWS  = 16,
    parameter int ROW_CNT_W = 5,
    parameter int TIMEOUT   = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ROW_CNT_W-1:0]        num_rows,
    output logic [2:0]                  mode,
    input  logic                        load_ready,
    input  logic                        layer_ready,
    input  logic [N_MACS-1:0]           weight_ctrl,
    input  logic [N_MACS*W_WIDTH-1:0]   w_in_data,
    input  logic                        w_in_valid,
    output logic                        w_in_ready,
    output logic [N_MACS*W_WIDTH-1:0]   mac_w_data,
    output logic [N_MACS-1:0]           mac_w_valid,
    output logic                        acc_rd_en,
    output logic [1:0]                  acc_rd_idx,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ_LOAD, S_STREAM, S_REQ_LAYER, S_READOUT, S_FINISH
    } state_t;

    state_t                 state;
    logic [ROW_CNT_W-1:0]   row_cnt;
    logic [ROW_CNT_W-1:0]   num_rows_q;
    logic                   xfer;
    logic                   last_row;
    logic                   num_rows_ok;

    assign busy        = (state != S_IDLE);
    // A row may already move in the cycle load_ready is first seen, before STREAM is entered.
    assign w_in_ready  = load_ready && ((state == S_REQ_LOAD) || (state == S_STREAM));
    assign xfer        = w_in_valid && w_in_ready;
    assign last_row    = xfer && ((row_cnt + ROW_CNT_W'(1)) == num_rows_q);
    assign num_rows_ok = (num_rows != '0) && (num_rows <= ROW_CNT_W'(MAX_ROWS));

`ifdef NN_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expired;
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            mode        <= 3'd0;
            row_cnt     <= '0;
            num_rows_q  <= '0;
            mac_w_data  <= '0;
            mac_w_valid <= '0;
            acc_rd_en   <= 1'b0;
            acc_rd_idx  <= 2'd0;
            done        <= 1'b0;
            err         <= 1'b0;
`ifdef NN_SEQ_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
        end else begin
            done        <= 1'b0;
            err         <= 1'b0;
            mac_w_valid <= '0;
`ifdef NN_SEQ_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
            if (xfer) begin
                mac_w_data  <= w_in_data;
                mac_w_valid <= weight_ctrl;
                row_cnt     <= row_cnt + ROW_CNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (num_rows_ok) begin
                            num_rows_q <= num_rows;
                            row_cnt    <= '0;
                            mode       <= 3'd1;
                            state      <= S_REQ_LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_REQ_LOAD, S_STREAM: begin
                    if (last_row) begin
                        mode  <= 3'd2;
                        state <= S_REQ_LAYER;
                    end else if (state == S_REQ_LOAD) begin
                        if (load_ready) begin
                            state <= S_STREAM;
                        end
`ifdef NN_SEQ_TIMEOUT_EN
                        else if (wd_expired) begin
                            err   <= 1'b1;
                            mode  <= 3'd0;
                            state <= S_IDLE;
                        end else begin
                            wd_cnt <= wd_cnt + WD_W'(1);
                        end
`endif
                    end
                end
                S_REQ_LAYER: begin
                    if (layer_ready) begin
                        acc_rd_en  <= 1'b1;
                        acc_rd_idx <= 2'd0;
                        state      <= S_READOUT;
                    end
`ifdef NN_SEQ_TIMEOUT_EN
                    else if (wd_expired) begin
                        err   <= 1'b1;
                        mode  <= 3'd0;
                        state <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                S_READOUT: begin
                    if (acc_rd_idx == 2'(N_MACS - 1)) begin
                        acc_rd_en <= 1'b0;
                        mode      <= 3'd0;
                        done      <= 1'b1;
                        state     <= S_FINISH;
                    end else begin
                        acc_rd_idx <= acc_rd_idx + 2'd1;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    mode  <= 3'd0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Randomized bench for nn_layer_sequencer with a timeline-level reference model of each load/readout job.
module tb_nn_layer_sequencer;

    localparam int N_MACS  = 4;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  num_rows = '0;
    logic [2:0]  mode;
    logic        load_ready = 1'b0;
    logic        layer_ready = 1'b0;
    logic [3:0]  weight_ctrl = '0;
    logic [31:0] w_in_data = '0;
    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [31:0] mac_w_data;
    logic [3:0]  mac_w_valid;
    logic        acc_rd_en;
    logic [1:0]  acc_rd_idx;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    nn_layer_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .mode(mode),
        .load_ready(load_ready), .layer_ready(layer_ready), .weight_ctrl(weight_ctrl),
        .w_in_data(w_in_data), .w_in_valid(w_in_valid), .w_in_ready(w_in_ready),
        .mac_w_data(mac_w_data), .mac_w_valid(mac_w_valid), .acc_rd_en(acc_rd_en),
        .acc_rd_idx(acc_rd_idx), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] row_word(input int i);
        logic [7:0] b;
        b = 8'(4 * i);
        return {b + 8'd4, b + 8'd3, b + 8'd2, b + 8'd1};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_mode"}, mode, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready"}, w_in_ready, 0);
        check({tag, "_mdata"}, mac_w_data, 0);
        check({tag, "_mvalid"}, mac_w_valid, 0);
        check({tag, "_rden"}, acc_rd_en, 0);
        check({tag, "_rdidx"}, acc_rd_idx, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // vmode: 0 valid held, 1 valid toggles, 2 random; smode: 0 no stall, 1 two-cycle drop after row 0, 2 random drops
    task automatic run_job(input int n, input int vmode, input int smode, input bit directed, input int abort_at);
        int xfers = 0;
        int cyc = 0;
        int lay_k = -1;
        int stall_left = 0;
        int ld_delay;
        int ly_wait;
        bit stalled = 1'b0;
        bit pend = 1'b0;
        bit tog = 1'b1;
        logic [31:0] exp_d = '0;
        logic [3:0]  exp_v = '0;
        ld_delay = directed ? 1 : int'($urandom_range(0, 3));
        ly_wait  = directed ? 1 : int'($urandom_range(0, 3));
        @(negedge clk);
        start = 1'b1;
        num_rows = 5'(n);
        @(negedge clk);
        start = 1'b0;
        forever begin
            if (lay_k >= 0) lay_k++;
            check("mac_w_valid", mac_w_valid, pend ? exp_v : 4'h0);
            if (pend) check("mac_w_data", mac_w_data, exp_d);
            check("mode", mode, (lay_k >= 5) ? 0 : ((xfers < n) ? 1 : 2));
            check("busy", busy, (lay_k < 6) ? 1 : 0);
            check("acc_rd_en", acc_rd_en, (lay_k >= 1 && lay_k <= 4) ? 1 : 0);
            if (lay_k >= 1 && lay_k <= 4) check("acc_rd_idx", acc_rd_idx, lay_k - 1);
            check("done", done, (lay_k == 5) ? 1 : 0);
            check("err", err, 0);
            if (lay_k == 6) break;
            if (cyc > 600) begin
                check("job_bound", 1, 0);
                break;
            end
            if (abort_at >= 0 && xfers == abort_at) begin
                rst = 1'b1;
                #1;
                check_all_zero("rst_mid");
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0; load_ready = 1'b0; w_in_valid = 1'b0; layer_ready = 1'b0;
                @(negedge clk);
                check_all_zero("post_rst");
                return;
            end
            if (xfers < n) begin
                load_ready = (cyc >= ld_delay);
                if (smode == 1 && xfers >= 1 && !stalled) begin
                    stalled = 1'b1;
                    stall_left = 2;
                end
                if (stall_left > 0) begin
                    load_ready = 1'b0;
                    stall_left--;
                end
                if (smode == 2 && $urandom_range(0, 3) == 0) load_ready = 1'b0;
            end else begin
                load_ready = 1'b0;
                if (lay_k < 0) begin
                    if (ly_wait == 0) begin
                        layer_ready = 1'b1;
                        lay_k = 0;
                    end else begin
                        ly_wait--;
                    end
                end
            end
            case (vmode)
                0: w_in_valid = (xfers < n);
                1: begin
                    w_in_valid = tog && (xfers < n);
                    tog = !tog;
                end
                default: w_in_valid = 1'($urandom_range(0, 1));
            endcase
            w_in_data   = (xfers < n && directed) ? row_word(xfers) : $urandom;
            weight_ctrl = directed ? 4'hF : 4'($urandom);
            start       = (vmode == 2) && ($urandom_range(0, 4) == 0);
            num_rows    = 5'($urandom);
            #1;
            check("w_in_ready", w_in_ready, ((xfers < n) && load_ready) ? 1 : 0);
            pend = w_in_valid && (xfers < n) && load_ready;
            if (pend) begin
                exp_d = w_in_data;
                exp_v = weight_ctrl;
                xfers++;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; layer_ready = 1'b0; w_in_valid = 1'b0; load_ready = 1'b0;
    endtask

    task automatic illegal_start(input int n);
        @(negedge clk);
        start = 1'b1;
        num_rows = 5'(n);
        @(negedge clk);
        start = 1'b0;
        check("illegal_err", err, 1);
        check("illegal_mode", mode, 0);
        check("illegal_busy", busy, 0);
        @(negedge clk);
        check("illegal_err_clear", err, 0);
        check("illegal_busy_after", busy, 0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        run_job(3, 0, 0, 1'b1, -1);
        run_job(3, 1, 0, 1'b1, -1);
        run_job(3, 0, 1, 1'b1, -1);
        illegal_start(0);
        illegal_start(17);
        illegal_start(int'($urandom_range(17, 31)));
        run_job(5, 0, 0, 1'b1, 2);
        run_job(1, 0, 0, 1'b1, -1);
        run_job(16, 0, 0, 1'b1, -1);
        for (int j = 0; j < 30; j++) begin
            run_job(int'($urandom_range(1, 16)), 2, 2, 1'b0, -1);
        end

`ifdef NN_SEQ_TIMEOUT_EN
        begin
            int cnt = 0;
            @(negedge clk);
            start = 1'b1;
            num_rows = 5'd1;
            @(negedge clk);
            start = 1'b0;
            load_ready = 1'b1;
            w_in_valid = 1'b1;
            w_in_data = row_word(0);
            weight_ctrl = 4'hF;
            @(negedge clk);
            load_ready = 1'b0;
            w_in_valid = 1'b0;
            check("to_enter_layer", mode, 2);
            while (!err && cnt < 100) begin
                @(negedge clk);
                cnt++;
                if (!err) check("to_no_done", done, 0);
            end
            check("to_cycles", cnt, TIMEOUT);
            check("to_mode", mode, 0);
            check("to_done", done, 0);
            @(negedge clk);
            check("to_busy", busy, 0);
            check("to_err_clear", err, 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
